ysyx_24070016_fetch_unit: RTL

Parametrised instruction-fetch front end with a decoupled request/response memory port and an in-order fetch buffer. It replaces the free-running PC register plus combinational instruction read with a handshaked stage. It sits between instruction memory and the IDU, sustains one instruction per cycle with a 1-cycle memory, and supports pipelined outstanding requests and branch/jump redirect with stale-response dropping.

---
 rtl/ysyx_24070016_fetch_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/ysyx_24070016_fetch_unit.sv
// Instruction-fetch front end: handshaked memory port, in-order fetch buffer,
// redirect with dropping of responses that belong to the abandoned stream.
module ysyx_24070016_fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     INST_W    = 32,
    parameter int unsigned     DEPTH     = 2,
    parameter logic [XLEN-1:0] RESET_VEC = 'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    // Back-to-back redirects against a slow memory can owe more than DEPTH drops.
    localparam int unsigned DW = CW + 2;

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   pc_q   [DEPTH];
    logic [INST_W-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0]  filled_q;
    logic [PW-1:0]     alloc_ptr;
    logic [PW-1:0]     fill_ptr;
    logic [PW-1:0]     head_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     pend_cnt;
    logic [DW-1:0]     drop_cnt;

    logic out_fire;
    logic req_fire;
    logic rsp_drop;
    logic rsp_fill;
    logic rsp_taken;

    assign out_valid      = filled_q[head_ptr];
    assign out_pc         = pc_q[head_ptr];
    assign out_inst       = inst_q[head_ptr];
    assign out_fire       = out_valid && out_ready;

    assign imem_req_valid = !redirect_valid && ((count < CW'(DEPTH)) || out_fire);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop  = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_fill  = imem_rsp_valid && (drop_cnt == '0) && (pend_cnt != '0);
    assign rsp_taken = rsp_drop || rsp_fill;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc  <= RESET_VEC;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            count     <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= '0;
        end else if (redirect_valid) begin
            fetch_pc  <= redirect_pc & ~XLEN'(3);
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            count     <= '0;
            pend_cnt  <= '0;
            // Everything still in flight now belongs to the old stream.
            drop_cnt  <= drop_cnt + DW'(pend_cnt) - DW'(rsp_taken);
        end else begin
            if (req_fire) begin
                fetch_pc  <= fetch_pc + XLEN'(4);
                alloc_ptr <= alloc_ptr + PW'(1);
            end
            if (rsp_fill) fill_ptr <= fill_ptr + PW'(1);
            if (out_fire) head_ptr <= head_ptr + PW'(1);
            if (rsp_drop) drop_cnt <= drop_cnt - DW'(1);
            count    <= count + CW'(req_fire) - CW'(out_fire);
            pend_cnt <= pend_cnt + CW'(req_fire) - CW'(rsp_fill);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || redirect_valid) begin
            filled_q <= '0;
        end else begin
            if (out_fire) filled_q[head_ptr] <= 1'b0;
            if (rsp_fill) filled_q[fill_ptr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) pc_q[alloc_ptr] <= fetch_pc;
        if (rsp_fill && !redirect_valid) inst_q[fill_ptr] <= imem_rsp_data;
    end

`ifndef SYNTHESIS
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> (drop_cnt != '0 || pend_cnt != '0));
`endif

endmodule
